// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        MAC,
        DRAIN,
        OUT,
        DONE
    } fir_state_t;

    // Word index to BRAM byte address.
    localparam int BYTE_SHIFT = 2;

    // Bit positions of the AXI-Lite control word at offset 0x00.
    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    // Index width for a ring of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAPE_NUM = 11;
    localparam int IDX_W    = idx_w(TAPE_NUM);

endpackage

// File: rtl/fir_ring_idx.sv
// fir_ring_idx: modulo-N up-counter with wrap flag and an (idx - sub) mod N lookback.
// Latency: idx updates one cycle after inc/clr; wrap and diff are combinational.
// Backpressure: none; the owner decides when to increment.
module fir_ring_idx #(
    parameter int N = 11,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] sub,
    output logic [W-1:0] idx,
    output logic         wrap,
    output logic [W-1:0] diff
);

    assign wrap = (idx == W'(N - 1));

    // Lookback wraps by adding N, so non-power-of-two rings stay correct.
    assign diff = (idx >= sub) ? (idx - sub) : (idx + W'(N) - sub);

    // Count 0..N-1 and wrap back to zero; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= wrap ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: ap_ctrl FSM, length-driven sample counting, tap/data BRAM addressing and AXIS handshakes.
// Latency: ss handshake at cycle t -> sm_tvalid first high at t+Tape_Num+2; one sample in flight.
// Backpressure: sm_tready low holds OUT with sm_tvalid high; ss_tready stays low until that output is taken.
// Optional: define FIR_TLAST_CHECK_EN to add the sticky err_tlast output.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic                   ap_done_clr,
    input  logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   cfg_busy,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   data_sel_zero,
    output logic                   mac_clr,
    output logic                   mac_en
`ifdef FIR_TLAST_CHECK_EN
    ,
    output logic                   err_tlast
`endif
);

    localparam int IW = idx_w(Tape_Num);

    fir_state_t             state;
    logic [pDATA_WIDTH-1:0] len_r;
    logic [pDATA_WIDTH-1:0] out_cnt;
    logic                   data_we_r;
    logic [IW-1:0]          k_idx;
    logic [IW-1:0]          head_idx;
    logic [IW-1:0]          k_diff;
    logic [IW-1:0]          rd_idx;
    logic                   k_wrap;
    logic                   head_wrap;
    logic                   start_acc;
    logic                   in_hs;
    logic                   out_hs;
    logic                   last_out;

    assign start_acc = ap_start && ((state == IDLE) || (state == DONE));
    assign in_hs     = ss_tready && ss_tvalid;
    assign out_hs    = sm_tvalid && sm_tready;
    assign last_out  = ((out_cnt + pDATA_WIDTH'(1)) == len_r);

    // k walks the clear sweep and the tap sweep; it wraps to 0 at the end of each.
    fir_ring_idx #(.N(Tape_Num), .W(IW)) u_k_idx (
        .clk  (axis_clk),
        .rst  (axis_rst),
        .clr  (start_acc),
        .inc  ((state == CLEAR) || (state == MAC)),
        .sub  ('0),
        .idx  (k_idx),
        .wrap (k_wrap),
        .diff (k_diff)
    );

    // head is the slot of the newest sample; its lookback by k addresses x[n-k].
    fir_ring_idx #(.N(Tape_Num), .W(IW)) u_head_idx (
        .clk  (axis_clk),
        .rst  (axis_rst),
        .clr  (start_acc),
        .inc  (out_hs),
        .sub  (k_idx),
        .idx  (head_idx),
        .wrap (head_wrap),
        .diff (rd_idx)
    );

    // Sample writes must line up with the handshake itself, so WE follows ss_tvalid in WAIT_IN.
    assign data_WE = (data_we_r || in_hs) ? 4'hF : 4'h0;

    // Decode BRAM byte addresses from the registered state and ring indices.
    always_comb begin
        tap_A  = '0;
        data_A = '0;
        case (state)
            CLEAR:   data_A = pADDR_WIDTH'(k_idx) << BYTE_SHIFT;
            WAIT_IN: data_A = pADDR_WIDTH'(head_idx) << BYTE_SHIFT;
            MAC: begin
                tap_A  = pADDR_WIDTH'(k_idx) << BYTE_SHIFT;
                data_A = pADDR_WIDTH'(rd_idx) << BYTE_SHIFT;
            end
            default: ;
        endcase
    end

    // Control FSM: every output flag is loaded with its value for the state being entered.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state         <= IDLE;
            len_r         <= '0;
            out_cnt       <= '0;
            ap_idle       <= 1'b1;
            ap_done       <= 1'b0;
            cfg_busy      <= 1'b0;
            ss_tready     <= 1'b0;
            sm_tvalid     <= 1'b0;
            sm_tlast      <= 1'b0;
            tap_EN        <= 1'b0;
            data_EN       <= 1'b0;
            data_we_r     <= 1'b0;
            data_sel_zero <= 1'b0;
            mac_clr       <= 1'b0;
            mac_en        <= 1'b0;
        end else begin
            mac_clr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ap_start) begin
                        state         <= CLEAR;
                        len_r         <= data_length;
                        out_cnt       <= '0;
                        ap_idle       <= 1'b0;
                        ap_done       <= 1'b0;
                        cfg_busy      <= 1'b1;
                        data_EN       <= 1'b1;
                        data_we_r     <= 1'b1;
                        data_sel_zero <= 1'b1;
                    end else if (ap_done_clr) begin
                        ap_done <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (k_wrap) begin
                        data_we_r     <= 1'b0;
                        data_sel_zero <= 1'b0;
                        if (len_r == '0) begin
                            state    <= DONE;
                            ap_done  <= 1'b1;
                            ap_idle  <= 1'b1;
                            cfg_busy <= 1'b0;
                            data_EN  <= 1'b0;
                        end else begin
                            state     <= WAIT_IN;
                            ss_tready <= 1'b1;
                        end
                    end
                end
                WAIT_IN: begin
                    if (ss_tvalid) begin
                        state     <= MAC;
                        ss_tready <= 1'b0;
                        tap_EN    <= 1'b1;
                        mac_clr   <= 1'b1;
                    end
                end
                MAC: begin
                    // Read data lags the address by one cycle, so accumulation starts at k=1.
                    if (k_idx == '0) begin
                        mac_en <= 1'b1;
                    end
                    if (k_wrap) begin
                        state   <= DRAIN;
                        tap_EN  <= 1'b0;
                        data_EN <= 1'b0;
                    end
                end
                DRAIN: begin
                    state     <= OUT;
                    mac_en    <= 1'b0;
                    sm_tvalid <= 1'b1;
                    sm_tlast  <= last_out;
                end
                OUT: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        out_cnt   <= out_cnt + pDATA_WIDTH'(1);
                        if (last_out) begin
                            state    <= DONE;
                            ap_done  <= 1'b1;
                            ap_idle  <= 1'b1;
                            cfg_busy <= 1'b0;
                        end else begin
                            state     <= WAIT_IN;
                            ss_tready <= 1'b1;
                            data_EN   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_TLAST_CHECK_EN
    // While waiting for a sample out_cnt equals the input count, so it locates the expected last input.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            err_tlast <= 1'b0;
        end else if (start_acc) begin
            err_tlast <= 1'b0;
        end else if (in_hs && (ss_tlast != ((out_cnt + pDATA_WIDTH'(1)) == len_r))) begin
            err_tlast <= 1'b1;
        end
    end

    logic unused_idx;
    assign unused_idx = ^{k_diff, head_wrap};
`else
    logic unused_idx;
    assign unused_idx = ^{k_diff, head_wrap, ss_tlast};
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          ap_start;
    logic          ap_done_clr;
    logic [DW-1:0] data_length;
    logic          ss_tvalid;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tready;
    logic          sm_tvalid;
    logic          sm_tlast;
    logic          ap_idle;
    logic          ap_done;
    logic          cfg_busy;
    logic          tap_EN;
    logic [AW-1:0] tap_A;
    logic          data_EN;
    logic [3:0]    data_WE;
    logic [AW-1:0] data_A;
    logic          data_sel_zero;
    logic          mac_clr;
    logic          mac_en;
`ifdef FIR_TLAST_CHECK_EN
    logic          err_tlast;
`endif

    int errors = 0;
    int checks = 0;

    // Environment: tap ROM, data BRAM and MAC datapath around the sequencer.
    logic [31:0] taps [NT];
    logic [31:0] dmem [NT];
    logic [31:0] ss_tdata;
    logic [31:0] tap_do;
    logic [31:0] data_do;
    logic [31:0] acc;

    fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .ap_start      (ap_start),
        .ap_done_clr   (ap_done_clr),
        .data_length   (data_length),
        .ss_tvalid     (ss_tvalid),
        .ss_tlast      (ss_tlast),
        .ss_tready     (ss_tready),
        .sm_tready     (sm_tready),
        .sm_tvalid     (sm_tvalid),
        .sm_tlast      (sm_tlast),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done),
        .cfg_busy      (cfg_busy),
        .tap_EN        (tap_EN),
        .tap_A         (tap_A),
        .data_EN       (data_EN),
        .data_WE       (data_WE),
        .data_A        (data_A),
        .data_sel_zero (data_sel_zero),
        .mac_clr       (mac_clr),
        .mac_en        (mac_en)
`ifdef FIR_TLAST_CHECK_EN
        ,
        .err_tlast     (err_tlast)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        if (tap_EN) tap_do <= taps[int'(tap_A >> 2)];
        if (data_EN) begin
            if (data_WE == 4'hF) dmem[int'(data_A >> 2)] <= data_sel_zero ? 32'd0 : ss_tdata;
            else                 data_do <= dmem[int'(data_A >> 2)];
        end
        if (mac_clr)     acc <= 32'd0;
        else if (mac_en) acc <= acc + tap_do * data_do;
    end

    // Direct-form FIR output n over the samples of one run (x[m<0] = 0).
    function automatic logic [31:0] ref_y(input logic [31:0] xs[$], input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < NT; k++)
            if (n - k >= 0) s = s + taps[k] * xs[n - k];
        return s;
    endfunction

    // One full run: start, clear sweep, len samples with random gaps and output stalls.
    task automatic do_job(input int len, input int gap_max, input int stall_min,
                          input int stall_max, input bit poke);
        logic [31:0] x[$];
        logic [31:0] y;
        int in_cnt, out_cnt, clr_cnt, gap, stall, t_in, budget, n;
        bit waiting, pending, ready_seen;
        x = {};
        for (int i = 0; i < len; i++) x.push_back($urandom_range(255, 0));
        for (int k = 0; k < NT; k++) taps[k] = $urandom_range(255, 0);
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        @(negedge axis_clk);
        data_length = len;
        ap_start = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        data_length = $urandom;
        checks++;
        if (ap_idle !== 1'b0 || ap_done !== 1'b0 || cfg_busy !== 1'b1)
            $display("FAIL job_start: idle=%b done=%b busy=%b, want 0 0 1", ap_idle, ap_done, cfg_busy);
        if (ap_idle !== 1'b0 || ap_done !== 1'b0 || cfg_busy !== 1'b1) errors++;
        in_cnt = 0; out_cnt = 0; clr_cnt = 0; t_in = 0; n = 0; stall = 0;
        waiting = 0; pending = 0; ready_seen = 0;
        gap = $urandom_range(gap_max, 0);
        budget = 200 + len * (NT + 8 + gap_max + stall_max);
        while (out_cnt < len && n < budget) begin
            ap_start = 1'b0;
            ap_done_clr = 1'b0;
            if (poke && n == NT + 5) begin
                ap_start = 1'b1;
                ap_done_clr = 1'b1;
                data_length = 1;
            end
            if (data_sel_zero && data_WE == 4'hF) begin
                checks++;
                if (data_A !== AW'(clr_cnt * 4) || ready_seen) begin
                    errors++;
                    $display("FAIL clear_write: addr=%h after_ready=%b, want %h", data_A, ready_seen, clr_cnt * 4);
                end
                clr_cnt++;
            end
            if (ss_tready && !ready_seen) begin
                ready_seen = 1;
                checks++;
                if (clr_cnt !== NT) begin
                    errors++;
                    $display("FAIL clear_count: got %0d writes, want %0d", clr_cnt, NT);
                end
            end
            ss_tvalid = 1'b0;
            ss_tlast = 1'b0;
            if (ss_tready) begin
                checks++;
                if (waiting || pending) begin
                    errors++;
                    $display("FAIL ready_in_flight: ss_tready=1 with output outstanding, want 0");
                end
                if (gap > 0) gap--;
                else if (in_cnt < len) begin
                    ss_tvalid = 1'b1;
                    ss_tdata = x[in_cnt];
                    ss_tlast = (in_cnt == len - 1);
                    #1;
                    checks++;
                    if (data_WE !== 4'hF || data_A !== AW'((in_cnt % NT) * 4) || data_sel_zero !== 1'b0) begin
                        errors++;
                        $display("FAIL in_write: we=%h addr=%h sz=%b, want f %h 0",
                                 data_WE, data_A, data_sel_zero, (in_cnt % NT) * 4);
                    end
                    t_in = n; waiting = 1; in_cnt++;
                    gap = $urandom_range(gap_max, 0);
                end
            end
            sm_tready = 1'($urandom_range(1, 0));
            if (sm_tvalid) begin
                sm_tready = 1'b0;
                if (waiting) begin
                    waiting = 0; pending = 1;
                    y = ref_y(x, out_cnt);
                    checks++;
                    if (n !== t_in + NT + 2) begin
                        errors++;
                        $display("FAIL out_latency: %0d cycles, want %0d", n - t_in, NT + 2);
                    end
                    checks++;
                    if (acc !== y) begin
                        errors++;
                        $display("FAIL fir_out[%0d]: got %0d want %0d", out_cnt, acc, y);
                    end
                    checks++;
                    if (sm_tlast !== (out_cnt == len - 1)) begin
                        errors++;
                        $display("FAIL tlast[%0d]: got %b want %b", out_cnt, sm_tlast, out_cnt == len - 1);
                    end
                    stall = $urandom_range(stall_max, stall_min);
                end else if (!pending) begin
                    checks++; errors++;
                    $display("FAIL spurious_valid: sm_tvalid=1 with no input, want 0");
                end
                if (stall > 0) stall--;
                else begin
                    sm_tready = 1'b1;
                    pending = 0;
                    out_cnt++;
                end
            end else if (pending) begin
                checks++; errors++;
                $display("FAIL valid_dropped: sm_tvalid=0 before handshake, want 1");
                pending = 0;
            end
            @(negedge axis_clk);
            n++;
        end
        ap_start = 1'b0;
        ap_done_clr = 1'b0;
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        checks++;
        if (out_cnt < len) begin
            errors++;
            $display("FAIL job_timeout: %0d of %0d outputs", out_cnt, len);
        end
        checks++;
        if (ap_done !== 1'b1 || ap_idle !== 1'b1 || cfg_busy !== 1'b0 || ss_tready !== 1'b0 || sm_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL done_state: done=%b idle=%b busy=%b rdy=%b vld=%b, want 1 1 0 0 0",
                     ap_done, ap_idle, cfg_busy, ss_tready, sm_tvalid);
        end
    endtask

    task automatic test_reset;
        axis_rst = 1'b1;
        repeat (3) @(negedge axis_clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: idle=%b done=%b, want 1 0", ap_idle, ap_done);
        end
        checks++;
        if ({ss_tready, sm_tvalid, sm_tlast, cfg_busy, tap_EN, tap_A, data_EN, data_WE, data_A,
             data_sel_zero, mac_clr, mac_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero, want all 0");
        end
        axis_rst = 1'b0;
        repeat (2) @(negedge axis_clk);
        checks++;
        if (ap_idle !== 1'b1 || cfg_busy !== 1'b0 || ss_tready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: idle=%b busy=%b rdy=%b, want 1 0 0", ap_idle, cfg_busy, ss_tready);
        end
    endtask

    task automatic test_basic;
        do_job(3, 0, 0, 0, 0);
    endtask

    task automatic test_clear_single;
        do_job(1, 2, 0, 1, 0);
    endtask

    task automatic test_wrap;
        do_job(13, 2, 0, 2, 0);
    endtask

    task automatic test_backpressure;
        do_job(4, 0, 5, 5, 0);
    endtask

    task automatic test_start_ignored;
        do_job(5, 1, 0, 1, 1);
    endtask

    task automatic test_zero_len;
        int n;
        bit rdy_seen;
        @(negedge axis_clk);
        data_length = 0;
        ap_start = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (ap_done !== 1'b1 && n < 40) begin
            if (ss_tready) rdy_seen = 1;
            @(negedge axis_clk);
            n++;
        end
        checks++;
        if (n !== NT) begin
            errors++;
            $display("FAIL zero_len_done: after %0d cycles, want %0d", n, NT);
        end
        checks++;
        if (rdy_seen || ap_idle !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_state: rdy_seen=%b idle=%b busy=%b, want 0 1 0", rdy_seen, ap_idle, cfg_busy);
        end
        ap_done_clr = 1'b1;
        @(negedge axis_clk);
        ap_done_clr = 1'b0;
        checks++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL done_clr: done=%b idle=%b, want 0 1", ap_done, ap_idle);
        end
    endtask

    task automatic test_reset_midrun;
        int hs, after, n;
        for (int k = 0; k < NT; k++) taps[k] = $urandom_range(255, 0);
        @(negedge axis_clk);
        data_length = 4;
        ap_start = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        sm_tready = 1'b1;
        hs = 0; after = 0; n = 0;
        while (n < 300 && !(hs == 2 && after == 3)) begin
            ss_tvalid = 1'b0;
            if (ss_tready && hs < 2) begin
                ss_tvalid = 1'b1;
                ss_tdata = $urandom_range(255, 0);
                hs++;
            end
            @(negedge axis_clk);
            n++;
            if (hs == 2) after++;
        end
        checks++;
        if (mac_en !== 1'b1 || tap_EN !== 1'b1 || ap_idle !== 1'b0) begin
            errors++;
            $display("FAIL midrun_mac: mac_en=%b tap_EN=%b idle=%b, want 1 1 0", mac_en, tap_EN, ap_idle);
        end
        sm_tready = 1'b0;
        axis_rst = 1'b1;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 ||
            {ss_tready, sm_tvalid, sm_tlast, cfg_busy, tap_EN, tap_A, data_EN, data_WE, data_A,
             data_sel_zero, mac_clr, mac_en} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: idle=%b done=%b or outputs nonzero, want 1 0 all-0", ap_idle, ap_done);
        end
        @(negedge axis_clk);
        axis_rst = 1'b0;
        do_job(3, 1, 0, 2, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) do_job($urandom_range(15, 1), 3, 0, 3, 0);
    endtask

    initial begin
        ap_start = 1'b0;
        ap_done_clr = 1'b0;
        data_length = '0;
        ss_tvalid = 1'b0;
        ss_tlast = 1'b0;
        ss_tdata = '0;
        sm_tready = 1'b0;
        for (int k = 0; k < NT; k++) taps[k] = 32'd0;
        test_reset;
        test_basic;
        test_clear_single;
        test_wrap;
        test_backpressure;
        test_zero_len;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
